csr_file_m: RTL and testbench

Parametrised machine-mode CSR file for the write-back stage, successor to the fixed seven-register CSR block. It adds CSR set/clear operations, `mscratch`, live interrupt-pending sampling with priority arbitration, a selectable direct/vectored `mtvec`, and configurable-width cycle, instret and hardware-performance counters gated by `mcountinhibit`. Trap entry, `mret` and CSR writes are all committed from write-back. Reads are combinational for the EX/WB read path.

---
 rtl/csr_file_m_if.sv | 15 +
 rtl/csr_file_m.sv | 225 ++++++++++++++++++++++
 tb/tb_csr_file_m.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_file_m_if.sv
// CSR read/write port between the write-back stage and the machine-mode CSR file.
interface csr_bus_if;
    logic        wr_en;
    logic [1:0]  wr_op;
    logic [11:0] wr_index;
    logic [31:0] wr_wdata;
    logic [11:0] rd_index;
    logic [31:0] rd_data;
    logic        rd_illegal;

    modport master (output wr_en, wr_op, wr_index, wr_wdata, rd_index,
                    input  rd_data, rd_illegal);
    modport slave  (input  wr_en, wr_op, wr_index, wr_wdata, rd_index,
                    output rd_data, rd_illegal);
endinterface

// File: rtl/csr_file_m.sv
// Machine-mode CSR file committed from write-back, with a combinational read port.
// Define CSR_COUNTERS_EN to build mcycle/minstret/mhpmcounter and mcountinhibit.

module csr_cnt_m #(
    parameter int W = 64
) (
    input  logic        clk,
    input  logic        cpurst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] val
);
    logic [W-1:0] q;

    assign val = 64'(q);

    // A write to either half suppresses the increment; the other half holds.
    always_ff @(posedge clk) begin
        if (cpurst)     q <= '0;
        else if (wr_lo) q <= W'({val[63:32], wdata});
        else if (wr_hi) q <= W'({wdata, val[31:0]});
        else if (inc)   q <= q + W'(1);
    end
endmodule

module csr_file_m #(
    parameter int          NUM_HPM   = 4,
    parameter int          CNT_WIDTH = 64,
    parameter logic [31:0] MTVEC_RST = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        cpurst,
    input  logic        trap_en,
    input  logic        trap_is_int,
    input  logic [4:0]  trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_val,
    input  logic        mret_en,
    csr_bus_if.slave    bus,
    input  logic        instr_retire,
    input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic        irq_sw,
    output logic        int_req,
    output logic [4:0]  int_cause,
    output logic [31:0] mstatus,
    output logic [31:0] mie,
    output logic [31:0] mtvec,
    output logic [31:0] mepc,
    output logic [31:0] mip,
    output logic [31:0] trap_target
);
    localparam logic [5:0] NCNT = 6'(3 + NUM_HPM);

    logic        mie_b, mpie;
    logic [2:0]  ie, ip;            // {MEI, MTI, MSI}
    logic [31:0] mtvec_q, mscratch, mcause, mtval;
    logic [29:0] mepc_q;
    logic [2:0]  pend;

    assign mstatus = {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie_b, 3'b0};
    assign mie     = {20'b0, ie[2], 3'b0, ie[1], 3'b0, ie[0], 3'b0};
    assign mip     = {20'b0, ip[2], 3'b0, ip[1], 3'b0, ip[0], 3'b0};
    assign mtvec   = mtvec_q;
    assign mepc    = {mepc_q, 2'b00};

`ifdef CSR_COUNTERS_EN
    logic [31:0]       inh;
    logic [31:0][63:0] cnt;
`endif

    function automatic logic cnt_addr(input logic [11:0] idx);
        return idx[11:8] == 4'hB && idx[6:5] == 2'b00 &&
               (idx[4:0] == 5'd0 || idx[4:0] == 5'd2 ||
                (idx[4:0] >= 5'd3 && {1'b0, idx[4:0]} < NCNT));
    endfunction

    // {illegal, data}; shared by the read port and the set/clear old-value path.
    function automatic logic [32:0] csr_rd(input logic [11:0] idx);
        logic [32:0] r;
        r = '0;
        case (idx)
            12'h300: r[31:0] = mstatus;
            12'h304: r[31:0] = mie;
            12'h305: r[31:0] = mtvec_q;
`ifdef CSR_COUNTERS_EN
            12'h320: r[31:0] = inh;
`else
            12'h320: r[31:0] = 32'h0;
`endif
            12'h340: r[31:0] = mscratch;
            12'h341: r[31:0] = mepc;
            12'h342: r[31:0] = mcause;
            12'h343: r[31:0] = mtval;
            12'h344: r[31:0] = mip;
            default: begin
                if (cnt_addr(idx)) begin
`ifdef CSR_COUNTERS_EN
                    r[31:0] = idx[7] ? cnt[idx[4:0]][63:32] : cnt[idx[4:0]][31:0];
`endif
                end else begin
                    r[32] = 1'b1;
                end
            end
        endcase
        return r;
    endfunction

    logic [32:0] rd_res, wr_old;
    logic        wr_act;
    logic [31:0] nv;

    always_comb begin
        rd_res = csr_rd(bus.rd_index);
        wr_old = csr_rd(bus.wr_index);
        wr_act = bus.wr_en && bus.wr_op != 2'b00 && !wr_old[32];
        case (bus.wr_op)
            2'b10:   nv = wr_old[31:0] | bus.wr_wdata;
            2'b11:   nv = wr_old[31:0] & ~bus.wr_wdata;
            default: nv = bus.wr_wdata;
        endcase
    end

    assign bus.rd_data    = rd_res[31:0];
    assign bus.rd_illegal = rd_res[32];

    always_ff @(posedge clk) begin
        if (cpurst) begin
            mie_b    <= 1'b0;
            mpie     <= 1'b0;
            ie       <= '0;
            ip       <= '0;
            mtvec_q  <= MTVEC_RST;
            mscratch <= '0;
            mepc_q   <= '0;
            mcause   <= '0;
            mtval    <= '0;
        end else begin
            ip <= {irq_ext, irq_timer, irq_sw};
            if (trap_en) begin
                mpie   <= mie_b;
                mie_b  <= 1'b0;
                mepc_q <= trap_pc[31:2];
                mtval  <= trap_val;
                mcause <= {trap_is_int, 26'b0, trap_cause};
            end else if (mret_en) begin
                mie_b <= mpie;
                mpie  <= 1'b1;
            end
            // Fields owned by a same-cycle trap or mret drop the write.
            if (wr_act) begin
                case (bus.wr_index)
                    12'h300: if (!trap_en && !mret_en) begin
                        mie_b <= nv[3];
                        mpie  <= nv[7];
                    end
                    12'h304: ie <= {nv[11], nv[7], nv[3]};
                    12'h305: mtvec_q <= {nv[31:2], 1'b0, nv[1] ? mtvec_q[0] : nv[0]};
                    12'h340: mscratch <= nv;
                    12'h341: if (!trap_en) mepc_q <= nv[31:2];
                    12'h342: if (!trap_en) mcause <= nv;
                    12'h343: if (!trap_en) mtval <= nv;
                    default: ;
                endcase
            end
        end
    end

    assign pend    = ie & ip;
    assign int_req = mie_b && |pend;

    always_comb begin
        int_cause = 5'd0;
        if (pend[2])      int_cause = 5'd11;
        else if (pend[0]) int_cause = 5'd3;
        else if (pend[1]) int_cause = 5'd7;
    end

    assign trap_target = (mtvec_q[0] && trap_is_int)
                       ? {mtvec_q[31:2], 2'b00} + {25'b0, trap_cause, 2'b00}
                       : {mtvec_q[31:2], 2'b00};

`ifdef CSR_COUNTERS_EN
    localparam logic [31:0] INH_MASK = 32'h5 | (((32'd1 << NUM_HPM) - 32'd1) << 3);
    logic cnt_wr;

    assign cnt_wr = wr_act && cnt_addr(bus.wr_index);

    always_ff @(posedge clk) begin
        if (cpurst) inh <= '0;
        else if (wr_act && bus.wr_index == 12'h320) inh <= nv & INH_MASK;
    end

    // Counter slots: 0 cycle, 2 instret, 3.. HPM; every other slot reads 0.
    for (genvar g = 0; g < 32; g++) begin : g_cnt
        if (g == 0 || g == 2 || (g >= 3 && g < 3 + NUM_HPM)) begin : g_on
            logic ev, hit;
            if (g == 0)      begin : g_cy assign ev = 1'b1;           end
            else if (g == 2) begin : g_ir assign ev = instr_retire;   end
            else             begin : g_hp assign ev = hpm_event[g-3]; end
            assign hit = cnt_wr && bus.wr_index[4:0] == 5'(g);
            csr_cnt_m #(.W(CNT_WIDTH)) u_cnt (
                .clk   (clk),
                .cpurst(cpurst),
                .inc   (ev && !inh[g]),
                .wr_lo (hit && !bus.wr_index[7]),
                .wr_hi (hit && bus.wr_index[7]),
                .wdata (nv),
                .val   (cnt[g])
            );
        end else begin : g_off
            assign cnt[g] = 64'h0;
        end
    end
`else
    logic unused_cnt;
    assign unused_cnt = ^{instr_retire, hpm_event};
`endif

    logic unused_pc;
    assign unused_pc = ^trap_pc[1:0];
endmodule

// File: tb/tb_csr_file_m.sv
// Randomized bench for csr_file_m against a per-cycle behavioural model of the CSR rules.
module tb_csr_file_m;
  localparam int NUM_HPM = 4;
  localparam int CNT_WIDTH = 40;
  localparam logic [63:0] CMASK = (64'd1 << CNT_WIDTH) - 64'd1;

  logic clk = 1'b0;
  logic cpurst, trap_en, trap_is_int, mret_en, instr_retire;
  logic irq_ext, irq_timer, irq_sw;
  logic [4:0] trap_cause;
  logic [31:0] trap_pc, trap_val;
  logic [NUM_HPM-1:0] hpm_event;
  logic int_req;
  logic [4:0] int_cause;
  logic [31:0] mstatus, mie, mtvec, mepc, mip, trap_target;

  always #10 clk = ~clk;

  csr_bus_if bus();

  csr_file_m #(.NUM_HPM(NUM_HPM), .CNT_WIDTH(CNT_WIDTH), .MTVEC_RST(32'h0000_0001)) dut (
    .clk(clk), .cpurst(cpurst), .trap_en(trap_en), .trap_is_int(trap_is_int),
    .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_val(trap_val), .mret_en(mret_en),
    .bus(bus), .instr_retire(instr_retire), .hpm_event(hpm_event),
    .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_sw(irq_sw),
    .int_req(int_req), .int_cause(int_cause), .mstatus(mstatus), .mie(mie),
    .mtvec(mtvec), .mepc(mepc), .mip(mip), .trap_target(trap_target));

  int n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---- reference model ----
  bit m_mieb, m_mpie;
  logic [31:0] m_mie, m_mtvec, m_scr, m_mepc, m_mcause, m_mtval, m_mip, m_inh;
  logic [63:0] m_cnt [32];

  function automatic bit cnt_ok(input logic [11:0] a);
    int n;
    if (!((a >= 12'hB00 && a <= 12'hB1F) || (a >= 12'hB80 && a <= 12'hB9F))) return 0;
    n = int'(a & 12'h1F);
    return n == 0 || n == 2 || (n >= 3 && n < 3 + NUM_HPM);
  endfunction

  function automatic logic [32:0] mread(input logic [11:0] a);
    logic [31:0] d;
    bit ill;
    d = 0; ill = 0;
    case (a)
      12'h300: d = 32'h1800 | (32'(m_mieb) << 3) | (32'(m_mpie) << 7);
      12'h304: d = m_mie;
      12'h305: d = m_mtvec;
      12'h320: d = m_inh;
      12'h340: d = m_scr;
      12'h341: d = m_mepc;
      12'h342: d = m_mcause;
      12'h343: d = m_mtval;
      12'h344: d = m_mip;
      default: begin
        if (cnt_ok(a)) begin
`ifdef CSR_COUNTERS_EN
          if (a >= 12'hB80) d = m_cnt[a & 12'h1F][63:32];
          else              d = m_cnt[a & 12'h1F][31:0];
`endif
        end else ill = 1;
      end
    endcase
    return {ill, d};
  endfunction

  task automatic model_reset();
    m_mieb = 0; m_mpie = 0; m_mie = 0; m_mtvec = 32'h1; m_scr = 0; m_mepc = 0;
    m_mcause = 0; m_mtval = 0; m_mip = 0; m_inh = 0;
    for (int n = 0; n < 32; n++) m_cnt[n] = 0;
  endtask

  task automatic model_step();
    logic [32:0] o;
    logic [31:0] nv, w;
    bit wr, ev;
    if (cpurst) begin model_reset(); return; end
    o = mread(bus.wr_index);
    w = bus.wr_wdata;
    wr = bus.wr_en && bus.wr_op != 2'b00 && !o[32];
    if (bus.wr_op == 2'b01) nv = w;
    else if (bus.wr_op == 2'b10) nv = o[31:0] | w;
    else nv = o[31:0] & ~w;
`ifdef CSR_COUNTERS_EN
    for (int n = 0; n < 3 + NUM_HPM; n++) begin
      if (n == 1) continue;
      if (n == 0) ev = 1;
      else if (n == 2) ev = instr_retire;
      else ev = hpm_event[n-3];
      if (wr && cnt_ok(bus.wr_index) && int'(bus.wr_index & 12'h1F) == n) begin
        if (bus.wr_index >= 12'hB80) m_cnt[n] = {nv, m_cnt[n][31:0]} & CMASK;
        else m_cnt[n] = {m_cnt[n][63:32], nv} & CMASK;
      end else if (ev && !m_inh[n]) m_cnt[n] = (m_cnt[n] + 1) & CMASK;
    end
    if (wr && bus.wr_index == 12'h320) m_inh = nv & (32'h5 | (((32'd1 << NUM_HPM) - 1) << 3));
`endif
    if (trap_en) begin
      m_mpie = m_mieb; m_mieb = 0;
      m_mepc = trap_pc & ~32'h3; m_mtval = trap_val;
      m_mcause = (32'(trap_is_int) << 31) | 32'(trap_cause);
    end else if (mret_en) begin
      m_mieb = m_mpie; m_mpie = 1;
    end
    if (wr) begin
      case (bus.wr_index)
        12'h300: if (!trap_en && !mret_en) begin m_mieb = nv[3]; m_mpie = nv[7]; end
        12'h304: m_mie = nv & 32'h888;
        12'h305: m_mtvec = (nv & ~32'h3) | (nv[1] ? (m_mtvec & 32'h3) : (nv & 32'h3));
        12'h340: m_scr = nv;
        12'h341: if (!trap_en) m_mepc = nv & ~32'h3;
        12'h342: if (!trap_en) m_mcause = nv;
        12'h343: if (!trap_en) m_mtval = nv;
        default: ;
      endcase
    end
    m_mip = (32'(irq_ext) << 11) | (32'(irq_timer) << 7) | (32'(irq_sw) << 3);
  endtask

  task automatic check_outs();
    logic [32:0] r;
    logic [31:0] pend, tt;
    int ec;
    r = mread(bus.rd_index);
    pend = m_mie & m_mip;
    ec = pend[11] ? 11 : pend[3] ? 3 : pend[7] ? 7 : 0;
    tt = m_mtvec & ~32'h3;
    if (m_mtvec[1:0] == 2'b01 && trap_is_int) tt = tt + 4 * 32'(trap_cause);
    check("rd_data", bus.rd_data, r[31:0]);
    check("rd_illegal", bus.rd_illegal, r[32]);
    check("mstatus", mstatus, mread(12'h300));
    check("mie", mie, m_mie);
    check("mtvec", mtvec, m_mtvec);
    check("mepc", mepc, m_mepc);
    check("mip", mip, m_mip);
    check("int_req", int_req, m_mieb && pend != 0);
    check("int_cause", int_cause, ec);
    check("trap_target", trap_target, tt);
  endtask

  // Inputs are already driven (after a negedge); check, then commit one edge.
  task automatic cyc();
    #1 check_outs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    cpurst = 0; trap_en = 0; trap_is_int = 0; trap_cause = 0; trap_pc = 0; trap_val = 0;
    mret_en = 0; instr_retire = 0; hpm_event = 0; irq_ext = 0; irq_timer = 0; irq_sw = 0;
    bus.wr_en = 0; bus.wr_op = 0; bus.wr_index = 0; bus.wr_wdata = 0;
  endtask

  task automatic csr_op(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    bus.wr_en = 1; bus.wr_op = op; bus.wr_index = a; bus.wr_wdata = d;
    cyc();
    bus.wr_en = 0; bus.wr_op = 0;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] e, input logic ill);
    bus.rd_index = a;
    #1;
    check(tag, bus.rd_data, e);
    check({tag, "_ill"}, bus.rd_illegal, ill);
  endtask

  function automatic logic [11:0] pick_addr();
    case ($urandom_range(0, 19))
      0: return 12'h300;  1: return 12'h304;  2: return 12'h305;  3: return 12'h320;
      4: return 12'h340;  5: return 12'h341;  6: return 12'h342;  7: return 12'h343;
      8: return 12'h344;  9: return 12'hB00; 10: return 12'hB80; 11: return 12'hB02;
     12: return 12'hB82; 13: return 12'hB03; 14: return 12'hB86; 15: return 12'hB06;
     16: return 12'hB07; 17: return 12'hB01; 18: return 12'h7C0;
     default: return 12'h300;
    endcase
  endfunction

  initial begin
    idle();
    bus.rd_index = 12'h300;
    cpurst = 1;
    model_reset();
    @(negedge clk);
    cyc(); cyc();
    cpurst = 0;

    rd_chk("rst_mstatus", 12'h300, 32'h0000_1800, 1'b0);
    rd_chk("rst_mtvec", 12'h305, 32'h0000_0001, 1'b0);
    rd_chk("rst_mcycle", 12'hB00, 32'h0, 1'b0);
    rd_chk("rst_7c0", 12'h7C0, 32'h0, 1'b1);
    check("rst_int_req", int_req, 0);
    check("rst_int_cause", int_cause, 0);

    csr_op(2'b01, 12'h304, 32'h808);
    csr_op(2'b10, 12'h300, 32'h8);
    irq_sw = 1; irq_ext = 1;
    cyc();
    #1 check("irq_req", int_req, 1);
    check("irq_cause_ext", int_cause, 11);
    irq_ext = 0;
    cyc();
    #1 check("irq_cause_sw", int_cause, 3);
    irq_sw = 0;
    cyc();

    csr_op(2'b01, 12'h305, 32'h8000_0101);
    trap_en = 1; trap_is_int = 1; trap_cause = 5'd7; trap_pc = 32'h2000; trap_val = 32'h55;
    #1 check("vec_target", trap_target, 32'h8000_011C);
    cyc();
    idle();
    rd_chk("trap_mcause", 12'h342, 32'h8000_0007, 1'b0);
    check("trap_mpie", mstatus[7], 1);
    check("trap_mie", mstatus[3], 0);
    mret_en = 1;
    cyc();
    mret_en = 0;
    #1 check("mret_mie", mstatus[3], 1);

    trap_en = 1; trap_is_int = 0; trap_cause = 5'd2; trap_pc = 32'hABCD_0004;
    csr_op(2'b01, 12'h341, 32'h1234);
    idle();
    rd_chk("trap_beats_wr", 12'h341, 32'hABCD_0004, 1'b0);
    csr_op(2'b11, 12'h300, 32'h8);
    #1 check("clr_mie", mstatus[3], 0);
    check("clr_mpp", mstatus[12:11], 2'b11);

`ifdef CSR_COUNTERS_EN
    csr_op(2'b01, 12'hB80, 32'h0);
    csr_op(2'b01, 12'hB00, 32'hFFFF_FFFF);
    rd_chk("cy_pre_lo", 12'hB00, 32'hFFFF_FFFF, 1'b0);
    rd_chk("cy_pre_hi", 12'hB80, 32'h0, 1'b0);
    cyc();
    rd_chk("cy_carry_lo", 12'hB00, 32'h0, 1'b0);
    rd_chk("cy_carry_hi", 12'hB80, 32'h1, 1'b0);
    csr_op(2'b01, 12'hB80, 32'hFFFF_FFFF);
    rd_chk("cy_hi_width", 12'hB80, 32'hFF, 1'b0);
    csr_op(2'b01, 12'hB00, 32'hFFFF_FFFF);
    cyc();
    rd_chk("cy_wrap_lo", 12'hB00, 32'h0, 1'b0);
    rd_chk("cy_wrap_hi", 12'hB80, 32'h0, 1'b0);
    csr_op(2'b01, 12'h320, 32'h5);
    csr_op(2'b01, 12'hB00, 32'h10);
    csr_op(2'b01, 12'hB02, 32'h20);
    csr_op(2'b01, 12'hB03, 32'h0);
    instr_retire = 1;
    for (int i = 0; i < 3; i++) begin
      hpm_event = 4'b0001; cyc();
      hpm_event = 4'b0000; cyc();
    end
    instr_retire = 0;
    rd_chk("inh_cycle", 12'hB00, 32'h10, 1'b0);
    rd_chk("inh_instret", 12'hB02, 32'h20, 1'b0);
    rd_chk("hpm3_count", 12'hB03, 32'h3, 1'b0);
    rd_chk("inh_reg", 12'h320, 32'h5, 1'b0);
    csr_op(2'b01, 12'h320, 32'h0);
`else
    csr_op(2'b01, 12'hB00, 32'h5);
    rd_chk("nocnt_mcycle", 12'hB00, 32'h0, 1'b0);
    rd_chk("nocnt_inh", 12'h320, 32'h0, 1'b0);
`endif

    for (int i = 0; i < 1500; i++) begin
      cpurst       = ($urandom_range(0, 63) == 0);
      trap_en      = ($urandom_range(0, 7) == 0);
      trap_is_int  = 1'($urandom);
      trap_cause   = 5'($urandom);
      trap_pc      = $urandom;
      trap_val     = $urandom;
      mret_en      = ($urandom_range(0, 7) == 0);
      instr_retire = 1'($urandom);
      hpm_event    = 4'($urandom);
      irq_ext      = 1'($urandom);
      irq_timer    = 1'($urandom);
      irq_sw       = 1'($urandom);
      bus.wr_en    = 1'($urandom);
      bus.wr_op    = 2'($urandom);
      bus.wr_index = pick_addr();
      bus.wr_wdata = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      bus.rd_index = pick_addr();
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
